// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and protection type.
// Pure declarations; no timing or flow-control behaviour of its own.
package axi4_lite_pkg;

  typedef logic [2:0] axi4_lite_prot_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_skid_buffer.sv
// Two-entry registered skid buffer: 1-cycle latency, one beat per cycle sustained.
// in_ready is a flop (!skid_full); at most two beats are held while out_ready is low.
module axi4_lite_skid_buffer #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [width-1:0] skid_data;
  logic             skid_full;
  logic             skid_full_nxt;
  logic             in_fire;
  logic             main_free;

  assign in_fire   = in_valid & in_ready;
  assign main_free = ~out_valid | out_ready;

  // Skid only fills when the main register is stalled; any drain of main empties it.
  always_comb begin
    skid_full_nxt = skid_full;
    if (main_free) begin
      skid_full_nxt = 1'b0;
    end else if (in_fire) begin
      skid_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      skid_data <= '0;
      skid_full <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      skid_full <= skid_full_nxt;
      in_ready  <= ~skid_full_nxt;
      if (main_free) begin
        if (skid_full) begin
          out_data  <= skid_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= in_fire;
          if (in_fire) begin
            out_data <= in_data;
          end
        end
      end else if (in_fire) begin
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_reg_slice.sv
// Full AXI4-Lite register slice: every channel through its own skid buffer, 1-cycle latency.
// Each channel back-pressures independently; readys are flops and drop only when two beats are held.
module axi4_lite_reg_slice
  import axi4_lite_pkg::*;
#(
  parameter int addr_width = 7,
  parameter int data_width = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic [addr_width-1:0]   s_axi_awaddr,
  input  axi4_lite_prot_t         s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [data_width-1:0]   s_axi_wdata,
  input  logic [data_width/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [addr_width-1:0]   s_axi_araddr,
  input  axi4_lite_prot_t         s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [data_width-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,

  output logic [addr_width-1:0]   m_axi_awaddr,
  output axi4_lite_prot_t         m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [data_width-1:0]   m_axi_wdata,
  output logic [data_width/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [addr_width-1:0]   m_axi_araddr,
  output axi4_lite_prot_t         m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [data_width-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int aw_w = addr_width + 3;
  localparam int w_w  = data_width + data_width / 8;
  localparam int b_w  = 2;
  localparam int ar_w = addr_width + 3;
  localparam int r_w  = data_width + 2;

  logic [aw_w-1:0] aw_out;
  logic [w_w-1:0]  w_out;
  logic [b_w-1:0]  b_out;
  logic [ar_w-1:0] ar_out;
  logic [r_w-1:0]  r_out;

  assign {m_axi_awprot, m_axi_awaddr} = aw_out;
  assign {m_axi_wstrb, m_axi_wdata}   = w_out;
  assign s_axi_bresp                  = b_out;
  assign {m_axi_arprot, m_axi_araddr} = ar_out;
  assign {s_axi_rresp, s_axi_rdata}   = r_out;

  axi4_lite_skid_buffer #(.width(aw_w)) u_aw (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({s_axi_awprot, s_axi_awaddr}),
    .in_valid  (s_axi_awvalid),
    .in_ready  (s_axi_awready),
    .out_data  (aw_out),
    .out_valid (m_axi_awvalid),
    .out_ready (m_axi_awready)
  );

  axi4_lite_skid_buffer #(.width(w_w)) u_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({s_axi_wstrb, s_axi_wdata}),
    .in_valid  (s_axi_wvalid),
    .in_ready  (s_axi_wready),
    .out_data  (w_out),
    .out_valid (m_axi_wvalid),
    .out_ready (m_axi_wready)
  );

  // Response channels flow slave -> master, so the slave side is the buffer input.
  axi4_lite_skid_buffer #(.width(b_w)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (m_axi_bresp),
    .in_valid  (m_axi_bvalid),
    .in_ready  (m_axi_bready),
    .out_data  (b_out),
    .out_valid (s_axi_bvalid),
    .out_ready (s_axi_bready)
  );

  axi4_lite_skid_buffer #(.width(ar_w)) u_ar (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({s_axi_arprot, s_axi_araddr}),
    .in_valid  (s_axi_arvalid),
    .in_ready  (s_axi_arready),
    .out_data  (ar_out),
    .out_valid (m_axi_arvalid),
    .out_ready (m_axi_arready)
  );

  axi4_lite_skid_buffer #(.width(r_w)) u_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({m_axi_rresp, m_axi_rdata}),
    .in_valid  (m_axi_rvalid),
    .in_ready  (m_axi_rready),
    .out_data  (r_out),
    .out_valid (s_axi_rvalid),
    .out_ready (s_axi_rready)
  );

endmodule

// File: tb/tb_axi4_lite_reg_slice.sv
// Bench for axi4_lite_reg_slice: per-channel FIFO occupancy model plus directed literal checks.
module tb_axi4_lite_reg_slice;
  import axi4_lite_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [6:0]  s_axi_awaddr = '0, m_axi_awaddr;
  logic [2:0]  s_axi_awprot = '0, m_axi_awprot;
  logic        s_axi_awvalid = 1'b0, s_axi_awready, m_axi_awvalid, m_axi_awready = 1'b1;
  logic [31:0] s_axi_wdata = '0, m_axi_wdata;
  logic [3:0]  s_axi_wstrb = '0, m_axi_wstrb;
  logic        s_axi_wvalid = 1'b0, s_axi_wready, m_axi_wvalid, m_axi_wready = 1'b1;
  logic [1:0]  s_axi_bresp, m_axi_bresp = '0;
  logic        s_axi_bvalid, s_axi_bready = 1'b1, m_axi_bvalid = 1'b0, m_axi_bready;
  logic [6:0]  s_axi_araddr = '0, m_axi_araddr;
  logic [2:0]  s_axi_arprot = '0, m_axi_arprot;
  logic        s_axi_arvalid = 1'b0, s_axi_arready, m_axi_arvalid, m_axi_arready = 1'b1;
  logic [31:0] s_axi_rdata, m_axi_rdata = '0;
  logic [1:0]  s_axi_rresp, m_axi_rresp = '0;
  logic        s_axi_rvalid, s_axi_rready = 1'b1, m_axi_rvalid = 1'b0, m_axi_rready;

  int errors = 0;
  int checks = 0;

  axi4_lite_reg_slice #(.addr_width(7), .data_width(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel views: 0=AW 1=W 2=B 3=AR 4=R, seen as source side (in) and sink side (out).
  string       chn [5] = '{"aw", "w", "b", "ar", "r"};
  logic [63:0] in_d [5];
  logic [63:0] out_d [5];
  logic        iv [5], ir [5], ov [5], orr [5];

  assign in_d[0] = 64'({s_axi_awprot, s_axi_awaddr});
  assign in_d[1] = 64'({s_axi_wstrb, s_axi_wdata});
  assign in_d[2] = 64'(m_axi_bresp);
  assign in_d[3] = 64'({s_axi_arprot, s_axi_araddr});
  assign in_d[4] = 64'({m_axi_rresp, m_axi_rdata});
  assign out_d[0] = 64'({m_axi_awprot, m_axi_awaddr});
  assign out_d[1] = 64'({m_axi_wstrb, m_axi_wdata});
  assign out_d[2] = 64'(s_axi_bresp);
  assign out_d[3] = 64'({m_axi_arprot, m_axi_araddr});
  assign out_d[4] = 64'({s_axi_rresp, s_axi_rdata});
  assign iv[0] = s_axi_awvalid;  assign ir[0] = s_axi_awready;
  assign iv[1] = s_axi_wvalid;   assign ir[1] = s_axi_wready;
  assign iv[2] = m_axi_bvalid;   assign ir[2] = m_axi_bready;
  assign iv[3] = s_axi_arvalid;  assign ir[3] = s_axi_arready;
  assign iv[4] = m_axi_rvalid;   assign ir[4] = m_axi_rready;
  assign ov[0] = m_axi_awvalid;  assign orr[0] = m_axi_awready;
  assign ov[1] = m_axi_wvalid;   assign orr[1] = m_axi_wready;
  assign ov[2] = s_axi_bvalid;   assign orr[2] = s_axi_bready;
  assign ov[3] = m_axi_arvalid;  assign orr[3] = m_axi_arready;
  assign ov[4] = s_axi_rvalid;   assign orr[4] = s_axi_rready;

  // Model: each channel is a 2-deep FIFO. Valid <=> non-empty, ready <=> fewer than 2 held
  // (but only once a clock edge has passed since reset), head of FIFO is the output payload.
  logic [63:0] q [5][$];
  logic        seen_edge;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen_edge <= 1'b0;
    else        seen_edge <= 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 5; c++) begin
        q[c].delete();
        check($sformatf("rst_%s_valid", chn[c]), 64'(ov[c]), 64'd0);
        check($sformatf("rst_%s_ready", chn[c]), 64'(ir[c]), 64'd0);
      end
    end else begin
      for (int c = 0; c < 5; c++) begin
        check($sformatf("model_%s_valid", chn[c]), 64'(ov[c]), 64'(q[c].size() > 0));
        check($sformatf("model_%s_ready", chn[c]), 64'(ir[c]),
              64'(seen_edge && (q[c].size() < 2)));
        if (ov[c] && q[c].size() > 0)
          check($sformatf("model_%s_data", chn[c]), out_d[c], q[c][0]);
      end
      for (int c = 0; c < 5; c++) begin
        if (ov[c] && orr[c] && q[c].size() > 0) void'(q[c].pop_front());
        if (iv[c] && ir[c]) q[c].push_back(in_d[c]);
      end
    end
  end

  logic [6:0]  addr_tbl [3] = '{7'h04, 7'h08, 7'h0C};
  logic [6:0]  got_addr [4];
  logic [1:0]  got_resp [4];
  int          acc, n, deliveries;
  logic        rdy, vld;

  initial begin
    // Reset with a pending AW beat
    s_axi_awvalid = 1'b1;
    s_axi_awaddr  = 7'h2A;
    s_axi_awprot  = 3'd5;
    #1 rst_n = 1'b0;
    tick(); tick();
    check("reset_awready", 64'(s_axi_awready), 64'd0);
    check("reset_awvalid", 64'(m_axi_awvalid), 64'd0);
    check("reset_wready", 64'(s_axi_wready), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    check("first_edge_awready", 64'(s_axi_awready), 64'd1);
    check("first_edge_m_awvalid", 64'(m_axi_awvalid), 64'd0);
    tick();
    s_axi_awvalid = 1'b0;
    check("second_edge_m_awvalid", 64'(m_axi_awvalid), 64'd1);
    check("second_edge_m_awaddr", 64'(m_axi_awaddr), 64'h2A);
    check("second_edge_m_awprot", 64'(m_axi_awprot), 64'd5);
    tick();

    // Streaming: 16 back-to-back W beats, each visible right after its accepting edge
    s_axi_wstrb = 4'hF;
    for (int i = 0; i < 16; i++) begin
      s_axi_wdata  = 32'(i);
      s_axi_wvalid = 1'b1;
      tick();
      check($sformatf("stream_wvalid_%0d", i), 64'(m_axi_wvalid), 64'd1);
      check($sformatf("stream_wdata_%0d", i), 64'(m_axi_wdata), 64'(i));
    end
    s_axi_wvalid = 1'b0;
    tick();
    check("stream_end_wvalid", 64'(m_axi_wvalid), 64'd0);

    // Backpressure: three AR beats offered against a stalled slave
    m_axi_arready = 1'b0;
    acc = 0;
    repeat (5) begin
      s_axi_araddr  = addr_tbl[acc];
      s_axi_arvalid = 1'b1;
      rdy = s_axi_arready;
      tick();
      if (rdy) acc++;
    end
    check("bp_accepted", 64'(acc), 64'd2);
    check("bp_arready_low", 64'(s_axi_arready), 64'd0);
    check("bp_head_addr", 64'(m_axi_araddr), 64'h04);
    m_axi_arready = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (acc < 3) begin
        s_axi_araddr  = addr_tbl[acc];
        s_axi_arvalid = 1'b1;
      end else begin
        s_axi_arvalid = 1'b0;
      end
      if (m_axi_arvalid && n < 4) begin
        got_addr[n] = m_axi_araddr;
        n++;
      end
      rdy = s_axi_arready;
      vld = s_axi_arvalid;
      tick();
      if (rdy && vld) acc++;
    end
    s_axi_arvalid = 1'b0;
    check("bp_drain_count", 64'(n), 64'd3);
    check("bp_drain_0", 64'(got_addr[0]), 64'h04);
    check("bp_drain_1", 64'(got_addr[1]), 64'h08);
    check("bp_drain_2", 64'(got_addr[2]), 64'h0C);

    // Response path: one R beat delivered under a randomly toggling master ready
    m_axi_rdata  = 32'hDEADBEEF;
    m_axi_rresp  = RESP_SLVERR;
    m_axi_rvalid = 1'b1;
    s_axi_rready = 1'b0;
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rdata  = 32'h0;
    m_axi_rresp  = RESP_OKAY;
    deliveries = 0;
    for (int k = 0; k < 20; k++) begin
      s_axi_rready = (k >= 17) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (s_axi_rvalid && s_axi_rready) begin
        deliveries++;
        check("r_data", 64'(s_axi_rdata), 64'hDEADBEEF);
        check("r_resp", 64'(s_axi_rresp), 64'(RESP_SLVERR));
      end
      tick();
    end
    s_axi_rready = 1'b1;
    check("r_deliveries", 64'(deliveries), 64'd1);

    // B flows while AW is stalled at the slave
    m_axi_awready = 1'b0;
    s_axi_awaddr  = 7'h11;
    s_axi_awprot  = 3'd3;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      s_axi_awvalid = (k == 0);
      m_axi_bvalid  = (k < 2);
      m_axi_bresp   = (k == 0) ? RESP_OKAY : RESP_SLVERR;
      if (s_axi_bvalid && s_axi_bready && n < 4) begin
        got_resp[n] = s_axi_bresp;
        n++;
      end
      tick();
    end
    m_axi_bvalid = 1'b0;
    check("b_count", 64'(n), 64'd2);
    check("b_resp_0", 64'(got_resp[0]), 64'(RESP_OKAY));
    check("b_resp_1", 64'(got_resp[1]), 64'(RESP_SLVERR));
    check("aw_stalled_valid", 64'(m_axi_awvalid), 64'd1);
    check("aw_stalled_addr", 64'(m_axi_awaddr), 64'h11);
    check("aw_stalled_prot", 64'(m_axi_awprot), 64'd3);
    m_axi_awready = 1'b1;
    tick();
    check("aw_resumed_drained", 64'(m_axi_awvalid), 64'd0);

    // Mid-op reset with two W beats buffered
    m_axi_wready = 1'b0;
    s_axi_wvalid = 1'b1;
    s_axi_wdata  = 32'hA1;
    tick();
    s_axi_wdata  = 32'hA2;
    tick();
    s_axi_wvalid = 1'b0;
    tick();
    check("midrst_pre_wvalid", 64'(m_axi_wvalid), 64'd1);
    check("midrst_pre_wready", 64'(s_axi_wready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_async_wvalid", 64'(m_axi_wvalid), 64'd0);
    check("midrst_async_wready", 64'(s_axi_wready), 64'd0);
    m_axi_wready = 1'b1;
    tick(); tick();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("midrst_no_stale_%0d", k), 64'(m_axi_wvalid), 64'd0);
    end

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
